// File: rtl/aes_job_sequencer_pkg.sv
// Shared types and register map for the AES job sequencer.
package aes_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_e;

  // Word indices; KEY/DIN/DOUT are 4-word blocks selected by addr[3:2]
  localparam logic [3:0] KEY_BASE  = 4'd0;
  localparam logic [3:0] DIN_BASE  = 4'd4;
  localparam logic [3:0] DOUT_BASE = 4'd8;
  localparam logic [3:0] CTRL      = 4'd12;
  localparam logic [3:0] STATUS    = 4'd13;
  localparam logic [3:0] JOBCNT    = 4'd14;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_TIMEOUT  = 2;
  localparam int ST_OVERRUN  = 3;

  typedef struct packed {
    logic start;
    logic irq_en;
    logic clr;
  } ctrl_wr_t;

  function automatic ctrl_wr_t ctrl_decode(input logic [31:0] d);
    ctrl_wr_t c;
    c.start  = d[CTRL_START];
    c.irq_en = d[CTRL_IRQ_EN];
    c.clr    = d[CTRL_CLR];
    return c;
  endfunction

endpackage

// File: rtl/aes_job_sequencer_if.sv
// Word-addressed register bus between the AXI4-Lite slave and the sequencer.
interface aes_job_sequencer_if;
  logic        reg_wr_en;
  logic [3:0]  reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic        reg_rd_en;
  logic [3:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic        reg_rd_valid;

  modport master (
    output reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
    input  reg_rd_data, reg_rd_valid
  );

  modport slave (
    input  reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
    output reg_rd_data, reg_rd_valid
  );
endinterface

// File: rtl/aes_job_sequencer_watchdog.sv
// WAIT-phase watchdog: clearable up-counter that holds at its terminal count.
module aes_seq_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt;

  assign tc = (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/aes_job_sequencer.sv
// AES job sequencer: register file, launch FSM, result capture and irq.
// Optional WAIT watchdog enabled by AES_JOB_SEQUENCER_TIMEOUT_EN.
module aes_job_sequencer
  import aes_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int JOBCNT_WIDTH   = 16
) (
  input  logic                ACLK,
  input  logic                ARESET,
  aes_job_sequencer_if.slave  bus,
  output logic [127:0]        core_key,
  output logic [127:0]        core_din,
  output logic                core_start,
  input  logic                core_done,
  input  logic [127:0]        core_dout,
  output logic                irq
);

  state_e                  state_q;
  logic [3:0][31:0]        key_q, din_q, dout_q;
  logic                    irq_en_q, done_q, timeout_q, overrun_q;
  logic [JOBCNT_WIDTH-1:0] jobcnt_q;
  logic                    busy, timeout_hit;
  logic                    ctrl_wr;
  ctrl_wr_t                ctrl;
  logic [31:0]             rd_word;

  assign busy    = (state_q != IDLE);
  assign ctrl_wr = bus.reg_wr_en && (bus.reg_wr_addr == CTRL);
  assign ctrl    = ctrl_decode(bus.reg_wr_data);

`ifdef AES_JOB_SEQUENCER_TIMEOUT_EN
  logic wd_tc;

  aes_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk (ACLK),
    .rst (ARESET),
    .clr (state_q == LAUNCH),
    .en  (state_q == WAIT),
    .tc  (wd_tc)
  );

  // core_done on the terminal edge takes priority in the FSM below
  assign timeout_hit = (state_q == WAIT) && wd_tc;
`else
  wire unused_timeout_cfg = TIMEOUT_CYCLES[0];
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= IDLE;
      key_q      <= '0;
      din_q      <= '0;
      dout_q     <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      jobcnt_q   <= '0;
      core_key   <= '0;
      core_din   <= '0;
      core_start <= 1'b0;
      irq        <= 1'b0;
    end else begin
      core_start <= 1'b0;
      irq        <= done_q & irq_en_q;

      if (bus.reg_wr_en) begin
        if (bus.reg_wr_addr[3:2] == KEY_BASE[3:2])
          key_q[bus.reg_wr_addr[1:0]] <= bus.reg_wr_data;
        else if (bus.reg_wr_addr[3:2] == DIN_BASE[3:2])
          din_q[bus.reg_wr_addr[1:0]] <= bus.reg_wr_data;
      end

      if (ctrl_wr) begin
        irq_en_q <= ctrl.irq_en;
        if (ctrl.clr) begin
          done_q    <= 1'b0;
          timeout_q <= 1'b0;
          overrun_q <= 1'b0;
        end
        if (ctrl.start && busy) overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (ctrl_wr && ctrl.start) begin
            state_q    <= LAUNCH;
            core_key   <= key_q;
            core_din   <= din_q;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            core_start <= 1'b1;
          end
        end
        LAUNCH: state_q <= WAIT;
        WAIT: begin
          if (core_done) begin
            state_q  <= IDLE;
            dout_q   <= core_dout;
            done_q   <= 1'b1;
            jobcnt_q <= jobcnt_q + 1'b1;
          end else if (timeout_hit) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (bus.reg_rd_addr[3:2])
      2'd0: rd_word = key_q[bus.reg_rd_addr[1:0]];
      2'd1: rd_word = din_q[bus.reg_rd_addr[1:0]];
      2'd2: rd_word = dout_q[bus.reg_rd_addr[1:0]];
      default: begin
        case (bus.reg_rd_addr)
          CTRL: rd_word[CTRL_IRQ_EN] = irq_en_q;
          STATUS: begin
            rd_word[ST_BUSY]     = busy;
            rd_word[ST_DONE]     = done_q;
`ifdef AES_JOB_SEQUENCER_TIMEOUT_EN
            rd_word[ST_TIMEOUT]  = timeout_q;
`endif
            rd_word[ST_OVERRUN]  = overrun_q;
          end
          JOBCNT: rd_word[JOBCNT_WIDTH-1:0] = jobcnt_q;
          default: rd_word = '0;
        endcase
      end
    endcase
  end

  // Read data is registered, so a same-edge write is not yet visible
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bus.reg_rd_data  <= '0;
      bus.reg_rd_valid <= 1'b0;
    end else begin
      bus.reg_rd_valid <= bus.reg_rd_en;
      bus.reg_rd_data  <= bus.reg_rd_en ? rd_word : '0;
    end
  end

endmodule

// File: doc/aes_job_sequencer.md
# aes_job_sequencer

Control sequencer between the AXI4-Lite register slave of the AES IP and the AES core. It holds 32-bit word-addressed key, plaintext and result registers and snapshots key and plaintext into the core. It launches one encryption per START command, waits for the core's done pulse under an optional watchdog, then captures the result, updates status and job count, and raises an interrupt.

## Interface
- TIMEOUT_CYCLES, 64: maximum WAIT duration in cycles before a job is aborted; must be ≥2.
- JOBCNT_WIDTH, 16: width of the completed-job counter; must be ≤32.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- reg_wr_en  in  1  word write strobe.
- reg_wr_addr  in  4  word index of the write.
- reg_wr_data  in  32  write data.
- reg_rd_en  in  1  read strobe.
- reg_rd_addr  in  4  word index of the read.
- reg_rd_data  out  32  registered read data.
- reg_rd_valid  out  1  high for one cycle when reg_rd_data is valid.
- core_key  out  128  key snapshot driven to the core.
- core_din  out  128  plaintext snapshot driven to the core.
- core_start  out  1  one-cycle launch pulse.
- core_done  in  1  one-cycle completion pulse from the core.
- core_dout  in  128  ciphertext; valid while core_done is high.
- irq  out  1  level interrupt.

## Operation
- Register map by word index. In every 128-bit field, word n maps to bits [32n+31:32n].
  - 0–3: KEY (RW).
  - 4–7: DIN (RW).
  - 8–11: DOUT (RO).
  - 12: CTRL. bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (RW); bit2 CLR (write-1 clears DONE, TIMEOUT and OVERRUN; reads 0).
  - 13: STATUS (RO). bit0 BUSY, bit1 DONE, bit2 TIMEOUT, bit3 OVERRUN.
  - 14: JOBCNT (RO, zero-extended).
  - 15: reads 0, writes ignored.
- Writes to RO or reserved words are ignored.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE → LAUNCH on a START write. The same edge copies KEY/DIN into core_key/core_din and clears DONE and TIMEOUT.
  - LAUNCH: core_start = 1 for exactly one cycle, then → WAIT.
  - WAIT → IDLE on core_done. The same edge latches core_dout into DOUT, sets DONE and increments JOBCNT, which wraps modulo 2^JOBCNT_WIDTH.
  - WAIT → IDLE on timeout (see Configuration). The same edge sets TIMEOUT; DOUT and JOBCNT are left unchanged.
- BUSY = (state != IDLE).
- irq = DONE & IRQ_EN, registered.
- START while BUSY: ignored and sets OVERRUN (sticky). The running job is unaffected.
- KEY/DIN writes while BUSY update the registers only. The core snapshot holds until the next launch.
- core_done outside WAIT is ignored. DOUT is not changed.
- CLR and START in the same write: clear first, then launch. The result is DONE = 0, BUSY = 1.
- core_done and a timeout on the same edge: done wins and TIMEOUT stays 0.
- Read and write of the same word on the same edge: the read returns the old value.
- ARESET, including mid-job: state IDLE and all registers 0. Every output is 0: reg_rd_data, reg_rd_valid, core_key, core_din, core_start, irq. An in-flight core_done after reset is ignored.

## Timing
- A write is accepted at the rising edge where reg_wr_en = 1. The written value is visible to reads from the next edge.
- A START accepted at edge c gives core_start high in cycle c+1 (LAUNCH) and BUSY = 1 from c+1. WAIT begins at c+2.
- core_done sampled high at edge d in WAIT: DOUT, DONE, JOBCNT and BUSY = 0 are visible after d. irq rises one cycle later.
- Read: reg_rd_en at edge r gives reg_rd_data and reg_rd_valid = 1 after r, for one cycle. Back-to-back reads run at 1 per cycle.
- Minimum job-to-job spacing is 3 cycles: a START can be accepted in IDLE at the edge after completion.

## Configuration
- Macro: AES_JOB_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A watchdog counts WAIT cycles from 0, reset on entry to WAIT.
  - At count TIMEOUT_CYCLES-1 without core_done, the next edge aborts the job, setting TIMEOUT and returning to IDLE.
  - WAIT therefore lasts at most TIMEOUT_CYCLES cycles.
- Undefined: there is no counter, WAIT lasts until core_done, and STATUS bit2 reads 0.

## Structure
- Package aes_seq_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT);
  - localparams for register word indices (KEY_BASE = 0, DIN_BASE = 4, DOUT_BASE = 8, CTRL = 12, STATUS = 13, JOBCNT = 14);
  - the CTRL/STATUS bit positions.
- One sub-module, aes_seq_watchdog: a clear/enable counter with a terminal-count flag. It is instantiated only under AES_JOB_SEQUENCER_TIMEOUT_EN.

## Test plan
The core model is behavioural with a 10-cycle latency and returns the FIPS-197 C.1 result.
- Nominal job: KEY = 000102…0f, DIN = 00112233…ff, IRQ_EN = 1, START → one core_start pulse, then DOUT = 69c4e0d86a7b0430d8cdb78070b4c55a, STATUS = 0x2, JOBCNT = 1, irq = 1. A subsequent CLR gives irq = 0 and STATUS = 0.
- Overrun: START written again 3 cycles after the first → single core_start, STATUS bit3 = 1, JOBCNT = 1 on completion.
- Snapshot: write KEY word0 = 0xdeadbeef during WAIT → core_key unchanged; the KEY0 readback is 0xdeadbeef.
- Timeout (macro on, TIMEOUT_CYCLES = 8, core never answers) → BUSY drops after exactly 8 WAIT cycles, STATUS = 0x4, DOUT and JOBCNT unchanged. With the macro off, BUSY is still 1 after 1000 cycles.
- Reset mid-WAIT: assert ARESET 2 cycles after core_start → all outputs 0 and state IDLE. A late core_done leaves DOUT = 0 and JOBCNT = 0.
- JOBCNT wrap: with JOBCNT_WIDTH = 4, run 17 jobs → JOBCNT = 1.
